// File: rtl/rxslide_pkg.sv
// Shared types and defaults for the GTH RXSLIDE controller.
// The optional slide statistics counter is enabled with `define RXSLIDE_STATS_EN.
package rxslide_pkg;

  typedef enum logic [2:0] {
    WAIT_RDY  = 3'd0,
    GUARD     = 3'd1,
    READY     = 3'd2,
    SLIDE     = 3'd3,
    RESET_REQ = 3'd4
  } rxslide_state_t;

  localparam int DEF_SLIDE_PULSE_CYCLES = 2;
  localparam int DEF_GUARD_CYCLES       = 64;
  localparam int DEF_SLIP_POSITIONS     = 20;
  localparam int DEF_MAX_WRAPS          = 2;
  localparam int SLIP_TOTAL_W           = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rxslide_timer.sv
// Loadable down-counter with a zero flag, shared by the slide pulse and the settle guard.
module rxslide_timer #(
  parameter int MAX_COUNT = 64,
  parameter int CNT_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1
) (
  input  logic             rxusrclk2,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Count down to zero and park there until the next load.
  always_ff @(posedge rxusrclk2) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/rxslide_ctrl.sv
// RXSLIDE sequencer: pulse timing, post-slide settle guard, slip position tracking, RX reset request.
// Optional feature macro: RXSLIDE_STATS_EN builds the saturating slip_total counter.
module rxslide_ctrl
  import rxslide_pkg::*;
#(
  parameter int SLIDE_PULSE_CYCLES = DEF_SLIDE_PULSE_CYCLES,
  parameter int GUARD_CYCLES       = DEF_GUARD_CYCLES,
  parameter int SLIP_POSITIONS     = DEF_SLIP_POSITIONS,
  parameter int MAX_WRAPS          = DEF_MAX_WRAPS,
  localparam int POS_W             = $clog2(SLIP_POSITIONS),
  localparam int WRAP_W            = $clog2(MAX_WRAPS + 1)
) (
  input  logic                    rxusrclk2,
  input  logic                    rst,
  input  logic                    bitslip,
  input  logic                    aligned,
  input  logic                    rxresetdone,
  output logic                    rxslide,
  output logic                    bitslip_rdy,
  output logic                    rx_reset_req,
  output logic [POS_W-1:0]        slip_pos,
  output logic [WRAP_W-1:0]       wrap_cnt,
  output logic [SLIP_TOTAL_W-1:0] slip_total
);

  localparam int TMR_MAX = max_int(SLIDE_PULSE_CYCLES, GUARD_CYCLES);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0]  SLIDE_LOAD = TMR_W'(SLIDE_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  GUARD_LOAD = TMR_W'(GUARD_CYCLES - 1);
  localparam logic [POS_W-1:0]  LAST_POS   = POS_W'(SLIP_POSITIONS - 1);
  localparam logic [WRAP_W-1:0] LAST_WRAP  = WRAP_W'(MAX_WRAPS - 1);

  rxslide_state_t    state_r, state_s;
  logic [POS_W-1:0]  slip_pos_r, pos_s;
  logic [WRAP_W-1:0] wrap_cnt_r, wrap_s, wrap_eff_s;
  logic              rxslide_r, bitslip_rdy_r, rx_reset_req_r;
  logic              load_s, slid_s, timer_zero_s;
  logic [TMR_W-1:0]  load_val_s;

  rxslide_timer #(.MAX_COUNT(TMR_MAX), .CNT_W(TMR_W)) u_timer (
    .rxusrclk2 (rxusrclk2),
    .rst       (rst),
    .load      (load_s),
    .load_val  (load_val_s),
    .zero      (timer_zero_s)
  );

  // Next-state, position and timer-load decisions; a dropped rxresetdone outranks bitslip.
  always_comb begin
    state_s    = state_r;
    pos_s      = slip_pos_r;
    wrap_s     = wrap_cnt_r;
    wrap_eff_s = wrap_cnt_r;
    load_s     = 1'b0;
    load_val_s = GUARD_LOAD;
    slid_s     = 1'b0;
    case (state_r)
      WAIT_RDY: begin
        if (rxresetdone) begin
          state_s = GUARD;
          load_s  = 1'b1;
        end else begin
          state_s = WAIT_RDY;
        end
      end
      GUARD: begin
        if (!rxresetdone) begin
          state_s = WAIT_RDY;
        end else if (timer_zero_s) begin
          state_s = READY;
        end else begin
          state_s = GUARD;
        end
      end
      READY: begin
        if (!rxresetdone) begin
          state_s = WAIT_RDY;
        end else begin
          // Lock clears the sweep count before any same-cycle increment.
          wrap_eff_s = aligned ? {WRAP_W{1'b0}} : wrap_cnt_r;
          wrap_s     = wrap_eff_s;
          if (bitslip) begin
            if ((slip_pos_r == LAST_POS) && (wrap_eff_s == LAST_WRAP)) begin
              state_s = RESET_REQ;
            end else begin
              state_s    = SLIDE;
              load_s     = 1'b1;
              load_val_s = SLIDE_LOAD;
              slid_s     = 1'b1;
              if (slip_pos_r == LAST_POS) begin
                pos_s  = {POS_W{1'b0}};
                wrap_s = wrap_eff_s + WRAP_W'(1);
              end else begin
                pos_s  = slip_pos_r + POS_W'(1);
              end
            end
          end else begin
            state_s = READY;
          end
        end
      end
      SLIDE: begin
        if (!rxresetdone) begin
          state_s = WAIT_RDY;
        end else if (timer_zero_s) begin
          state_s = GUARD;
          load_s  = 1'b1;
        end else begin
          state_s = SLIDE;
        end
      end
      RESET_REQ: begin
        if (!rxresetdone) begin
          state_s = WAIT_RDY;
          pos_s   = {POS_W{1'b0}};
          wrap_s  = {WRAP_W{1'b0}};
        end else begin
          state_s = RESET_REQ;
        end
      end
      default: begin
        state_s = WAIT_RDY;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge rxusrclk2) begin
    if (rst) begin
      state_r        <= WAIT_RDY;
      slip_pos_r     <= {POS_W{1'b0}};
      wrap_cnt_r     <= {WRAP_W{1'b0}};
      rxslide_r      <= 1'b0;
      bitslip_rdy_r  <= 1'b0;
      rx_reset_req_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      slip_pos_r     <= pos_s;
      wrap_cnt_r     <= wrap_s;
      rxslide_r      <= (state_s == SLIDE);
      bitslip_rdy_r  <= (state_s == READY);
      rx_reset_req_r <= (state_s == RESET_REQ);
    end
  end

  assign rxslide      = rxslide_r;
  assign bitslip_rdy  = bitslip_rdy_r;
  assign rx_reset_req = rx_reset_req_r;
  assign slip_pos     = slip_pos_r;
  assign wrap_cnt     = wrap_cnt_r;

`ifdef RXSLIDE_STATS_EN
  logic [SLIP_TOTAL_W-1:0] slip_total_r;

  // Saturating count of issued slides.
  always_ff @(posedge rxusrclk2) begin
    if (rst) begin
      slip_total_r <= {SLIP_TOTAL_W{1'b0}};
    end else if (slid_s && (slip_total_r != {SLIP_TOTAL_W{1'b1}})) begin
      slip_total_r <= slip_total_r + SLIP_TOTAL_W'(1);
    end else begin
      slip_total_r <= slip_total_r;
    end
  end

  assign slip_total = slip_total_r;
`else
  assign slip_total = {SLIP_TOTAL_W{1'b0}};
`endif

endmodule

// File: tb/tb_rxslide_ctrl.sv
// Self-checking bench for rxslide_ctrl: vector table, per-cycle scoreboard, multi-cycle sequences.
module tb_rxslide_ctrl;

  localparam int P  = 2;
  localparam int G  = 64;
  localparam int S  = 20;
  localparam int MW = 2;
`ifdef RXSLIDE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        rxusrclk2 = 1'b0;
  logic        rst, bitslip, aligned, rxresetdone;
  logic        rxslide, bitslip_rdy, rx_reset_req;
  logic [4:0]  slip_pos;
  logic [1:0]  wrap_cnt;
  logic [15:0] slip_total;

  always #5 rxusrclk2 = ~rxusrclk2;

  rxslide_ctrl #(
    .SLIDE_PULSE_CYCLES (P),
    .GUARD_CYCLES       (G),
    .SLIP_POSITIONS     (S),
    .MAX_WRAPS          (MW)
  ) dut (
    .rxusrclk2    (rxusrclk2),
    .rst          (rst),
    .bitslip      (bitslip),
    .aligned      (aligned),
    .rxresetdone  (rxresetdone),
    .rxslide      (rxslide),
    .bitslip_rdy  (bitslip_rdy),
    .rx_reset_req (rx_reset_req),
    .slip_pos     (slip_pos),
    .wrap_cnt     (wrap_cnt),
    .slip_total   (slip_total)
  );

  typedef struct {
    int slide; int rdy; int req; int pos; int wrap; int tot;
  } exp_t;

  typedef struct {
    logic bs; logic al; logic rd; int n;
    int slide; int rdy; int req; int pos; int wrap; int tot;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[9];
  int   n_checks, n_fail, cyc, slide_hi_cnt;

  // Reference model: timeline-based, states 0 wait, 1 guard, 2 ready, 3 slide, 4 reset request.
  int m_state, m_rdy_at, m_slide_end, m_pos, m_wrap, m_total;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  function void model_reset();
    m_state = 0; m_rdy_at = 0; m_slide_end = 0;
    m_pos = 0; m_wrap = 0; m_total = 0;
  endfunction

  function void model_step(input logic bs, input logic al, input logic rd);
    case (m_state)
      0: if (rd) begin m_state = 1; m_rdy_at = cyc + 1 + G; end
      1: if (!rd) m_state = 0; else if (cyc + 1 == m_rdy_at) m_state = 2;
      2: if (!rd) m_state = 0;
         else begin
           if (al) m_wrap = 0;
           if (bs) begin
             if (m_pos == S - 1 && m_wrap == MW - 1) m_state = 4;
             else begin
               m_state = 3;
               m_slide_end = cyc + P;
               m_rdy_at = cyc + 1 + P + G;
               m_pos = (m_pos + 1) % S;
               if (m_pos == 0) m_wrap++;
               if (STATS && m_total < 65535) m_total++;
             end
           end
         end
      3: if (!rd) m_state = 0; else if (cyc == m_slide_end) m_state = 1;
      4: if (!rd) begin m_state = 0; m_pos = 0; m_wrap = 0; end
      default: m_state = 0;
    endcase
  endfunction

  task automatic tick(input logic bs, input logic al, input logic rd);
    exp_t e;
    bitslip = bs; aligned = al; rxresetdone = rd;
    model_step(bs, al, rd);
    e.slide = (m_state == 3); e.rdy = (m_state == 2); e.req = (m_state == 4);
    e.pos = m_pos; e.wrap = m_wrap; e.tot = m_total;
    sb_q.push_back(e);
    @(posedge rxusrclk2);
    #1;
    cyc++;
    e = sb_q.pop_front();
    chk("sb_rxslide", 32'(rxslide), 32'(e.slide));
    chk("sb_bitslip_rdy", 32'(bitslip_rdy), 32'(e.rdy));
    chk("sb_rx_reset_req", 32'(rx_reset_req), 32'(e.req));
    chk("sb_slip_pos", 32'(slip_pos), 32'(e.pos));
    chk("sb_wrap_cnt", 32'(wrap_cnt), 32'(e.wrap));
    chk("sb_slip_total", 32'(slip_total), 32'(e.tot));
    if (rxslide === 1'b1) slide_hi_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1; bitslip = 1'b0; aligned = 1'b0; rxresetdone = 1'b0;
    repeat (3) @(posedge rxusrclk2);
    #1;
    chk("rst_rxslide", 32'(rxslide), 32'd0);
    chk("rst_bitslip_rdy", 32'(bitslip_rdy), 32'd0);
    chk("rst_rx_reset_req", 32'(rx_reset_req), 32'd0);
    chk("rst_slip_pos", 32'(slip_pos), 32'd0);
    chk("rst_wrap_cnt", 32'(wrap_cnt), 32'd0);
    chk("rst_slip_total", 32'(slip_total), 32'd0);
    rst = 1'b0;
    model_reset();
    cyc = 0;
    slide_hi_cnt = 0;
  endtask

  // Idle with rxresetdone high until the model expects READY, bounded.
  task automatic wait_ready();
    int k;
    k = 0;
    while (m_state != 2 && k < 300) begin
      tick(1'b0, 1'b0, 1'b1);
      k++;
    end
    chk("ready_reached", 32'(bitslip_rdy), 32'd1);
  endtask

  task automatic slip(input logic al);
    wait_ready();
    tick(1'b1, al, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; slide_hi_cnt = 0;
    model_reset();

    //            bs    al    rd    n   sl rdy req pos wrap tot
    tbl[0] = '{1'b0, 1'b0, 1'b0, 10, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 64, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1,  0, 1, 0, 0, 0, 0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1,  1, 0, 0, 1, 0, 1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1,  1, 0, 0, 1, 0, 1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1,  0, 0, 0, 1, 0, 1};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 63, 0, 0, 0, 1, 0, 1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1,  0, 1, 0, 1, 0, 1};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1,  1, 0, 0, 2, 0, 2};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      repeat (tbl[i].n) tick(tbl[i].bs, tbl[i].al, tbl[i].rd);
      chk($sformatf("tbl%0d_rxslide", i), 32'(rxslide), 32'(tbl[i].slide));
      chk($sformatf("tbl%0d_bitslip_rdy", i), 32'(bitslip_rdy), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_rx_reset_req", i), 32'(rx_reset_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_slip_pos", i), 32'(slip_pos), 32'(tbl[i].pos));
      chk($sformatf("tbl%0d_wrap_cnt", i), 32'(wrap_cnt), 32'(tbl[i].wrap));
      chk($sformatf("tbl%0d_slip_total", i), 32'(slip_total), STATS ? 32'(tbl[i].tot) : 32'd0);
    end

    // 40 slips without lock: the 40th requests an RX reset instead of sliding.
    do_reset();
    for (int i = 0; i < 39; i++) slip(1'b0);
    wait_ready();
    chk("sweep_pos_39", 32'(slip_pos), 32'd19);
    chk("sweep_wrap_39", 32'(wrap_cnt), 32'd1);
    slip(1'b0);
    chk("sweep_req_40", 32'(rx_reset_req), 32'd1);
    chk("sweep_no_slide_40", 32'(rxslide), 32'd0);
    repeat (5) tick(1'b1, 1'b0, 1'b1);
    chk("sweep_req_held", 32'(rx_reset_req), 32'd1);
    chk("sweep_pulse_cycles", 32'(slide_hi_cnt), 32'd78);
    tick(1'b0, 1'b0, 1'b0);
    chk("sweep_req_clear", 32'(rx_reset_req), 32'd0);
    chk("sweep_pos_clear", 32'(slip_pos), 32'd0);
    chk("sweep_wrap_clear", 32'(wrap_cnt), 32'd0);
    wait_ready();

    // Lock after 25 slips clears the sweep count; 15 more slips stay below the limit.
    do_reset();
    for (int i = 0; i < 25; i++) slip(1'b0);
    wait_ready();
    chk("lock_wrap_before", 32'(wrap_cnt), 32'd1);
    chk("lock_pos_before", 32'(slip_pos), 32'd5);
    tick(1'b0, 1'b1, 1'b1);
    chk("lock_wrap_cleared", 32'(wrap_cnt), 32'd0);
    for (int i = 0; i < 15; i++) slip(1'b0);
    wait_ready();
    chk("lock_no_req", 32'(rx_reset_req), 32'd0);
    chk("lock_pos_after", 32'(slip_pos), 32'd0);
    chk("lock_wrap_after", 32'(wrap_cnt), 32'd1);

    // rxresetdone drops mid-slide, then outranks a bitslip in READY.
    do_reset();
    slip(1'b0);
    slip(1'b0);
    chk("drop_in_slide", 32'(rxslide), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    chk("drop_rxslide", 32'(rxslide), 32'd0);
    chk("drop_rdy", 32'(bitslip_rdy), 32'd0);
    chk("drop_pos_kept", 32'(slip_pos), 32'd2);
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    chk("drop_wait_pos", 32'(slip_pos), 32'd2);
    wait_ready();
    tick(1'b1, 1'b0, 1'b0);
    chk("prio_no_slide", 32'(rxslide), 32'd0);
    chk("prio_pos_kept", 32'(slip_pos), 32'd2);
    wait_ready();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rxslide_ctrl.md
# rxslide_ctrl

Drives the GTH RXSLIDE port on behalf of the comma-based RX aligner. It turns the aligner's single-cycle `bitslip` request into a correctly timed RXSLIDE pulse and enforces the post-slide settling guard, during which `bitslip_rdy` is low. It tracks the current slip position. If every bit position has been tried too often without lock, it requests a transceiver RX reset. It sits between the RX aligner and the GT channel wrapper in the `rxusrclk2` domain.

## Interface
- `SLIDE_PULSE_CYCLES`, 2: width of the RXSLIDE high pulse, in `rxusrclk2` cycles (≥1).
- `GUARD_CYCLES`, 64: settle time after RXSLIDE falls, before `bitslip_rdy` rises (≥32 per GT rules).
- `SLIP_POSITIONS`, 20: number of distinct bit positions; `slip_pos` wraps modulo this value.
- `MAX_WRAPS`, 2: number of full position sweeps without lock before an RX reset is requested (≥1).
- `rxusrclk2` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `bitslip` in 1: slip request pulse from the aligner.
- `aligned` in 1: aligner lock indication.
- `rxresetdone` in 1: GT RX reset complete. Synchronous to `rxusrclk2`.
- `rxslide` out 1: to GT RXSLIDE.
- `bitslip_rdy` out 1: to the aligner. High means a slip will be accepted and data is settled.
- `rx_reset_req` out 1: request to the reset controller for a GT RX reset.
- `slip_pos` out $clog2(SLIP_POSITIONS): current bit offset.
- `wrap_cnt` out $clog2(MAX_WRAPS+1): sweeps completed since the last lock or reset.
- `slip_total` out 16: saturating count of slides issued.

## Operation
- FSM states: WAIT_RDY, GUARD, READY, SLIDE, RESET_REQ. All outputs are registered.
- Reset values: state WAIT_RDY. `rxslide`, `bitslip_rdy`, `rx_reset_req` = 0. `slip_pos`, `wrap_cnt`, `slip_total` = 0.
- WAIT_RDY: when `rxresetdone`=1, load the guard counter with GUARD_CYCLES-1 and go to GUARD.
- GUARD: decrement the counter. At 0, go to READY.
- READY: `bitslip_rdy`=1. If `aligned`=1, clear `wrap_cnt`. On `bitslip`=1:
  - If `slip_pos`=SLIP_POSITIONS-1 and `wrap_cnt`=MAX_WRAPS-1: go to RESET_REQ. No slide is issued.
  - Otherwise: go to SLIDE. Increment `slip_pos` modulo SLIP_POSITIONS. On wrap to 0, increment `wrap_cnt`.
- SLIDE: `rxslide`=1 for SLIDE_PULSE_CYCLES cycles, then load the guard counter and go to GUARD.
- RESET_REQ: `rx_reset_req`=1 until `rxresetdone` is sampled 0. Then clear `slip_pos` and `wrap_cnt`, deassert the request, and go to WAIT_RDY.
- In GUARD, READY and SLIDE, `rxresetdone`=0 forces WAIT_RDY, with `rxslide`=0 and `bitslip_rdy`=0 next cycle. `slip_pos` and `wrap_cnt` are kept.
- `bitslip` outside READY is dropped, not queued. The aligner re-requests on its next timeout.
- `aligned` is ignored outside READY.

## Timing
- `bitslip` sampled at cycle n in READY:
  - `bitslip_rdy`=0 from n+1.
  - `rxslide`=1 for cycles n+1 … n+SLIDE_PULSE_CYCLES.
  - `bitslip_rdy`=1 again at n+1+SLIDE_PULSE_CYCLES+GUARD_CYCLES.
- `slip_pos`, `wrap_cnt` and `slip_total` update at n+1.
- WAIT_RDY exit: `rxresetdone` rises at cycle m → `bitslip_rdy`=1 at m+1+GUARD_CYCLES.
- Simultaneous events, in priority order: `rst`, then `rxresetdone`=0, then `bitslip`.
- `bitslip` and `aligned` high in the same READY cycle: the slide is taken and `wrap_cnt` is cleared before the increment.
- `slip_total` saturates at 16'hFFFF.

## Configuration
- `RXSLIDE_STATS_EN` defined: the `slip_total` counter is built.
- `RXSLIDE_STATS_EN` undefined: the `slip_total` port still exists, tied to 0, and no counter logic is generated. All other behaviour is identical.

## Structure
- Package `rxslide_pkg` holds:
  - the `rxslide_state_t` enum (the five states);
  - default parameter constants;
  - the `SLIP_TOTAL_W`=16 constant.
- One sub-module, `rxslide_timer`: a loadable down-counter with a zero flag. It is shared by SLIDE and GUARD, sized to max(SLIDE_PULSE_CYCLES, GUARD_CYCLES).

## Test plan
All scenarios use default parameters except where stated.
- Reset, then `rxresetdone`=1 at cycle 10 → `bitslip_rdy`=1 at cycle 75. All other outputs stay 0.
- Single `bitslip` in READY at cycle n → `rxslide` high for exactly cycles n+1 and n+2; `bitslip_rdy` low over n+1…n+66; `slip_pos`=1 and `slip_total`=1 at n+1.
- `bitslip` pulses during SLIDE and GUARD → ignored; `slip_pos` advances by 1 only.
- 40 accepted slips with `aligned`=0 → the 40th raises `rx_reset_req` with no `rxslide` pulse. `rxresetdone`→0 clears `slip_pos` and `wrap_cnt` and clears the request.
- `aligned`=1 in READY after 25 slips → `wrap_cnt`=0. The next 15 slips do not reach RESET_REQ.
- `rxresetdone` dropped mid-SLIDE → `rxslide`=0 next cycle, state WAIT_RDY, `slip_pos` retained. With `RXSLIDE_STATS_EN` undefined, `slip_total` stays 0 throughout.
